// File: rtl/router_pkt_ctrl.sv
// Write-side controller for the three router output FIFOs: header decode, write steering,
// parity check and per-port stall timeout. Define ROUTER_CTRL_STATS_EN for drop/parity-error counters.
module router_pkt_ctrl #(
    parameter int TIMEOUT = 30,
    parameter int TO_W    = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pkt_valid,
    input  logic [7:0] data_in,
    input  logic [2:0] fifo_full,
    input  logic [2:0] fifo_empty,
    input  logic [2:0] read_enb,
    output logic [7:0] data_out,
    output logic [2:0] write_enb,
    output logic       lfd_state,
    output logic       busy,
    output logic       err,
    output logic [2:0] vld_out,
    output logic [2:0] soft_reset
`ifdef ROUTER_CTRL_STATS_EN
    ,
    output logic [7:0] drop_cnt,
    output logic [7:0] perr_cnt
`endif
);
    typedef enum logic [2:0] {IDLE, WAIT_EMPTY, PAYLOAD, PARITY, CHECK, DROP} state_t;

    state_t              state, state_nx;
    logic [1:0]          addr_q, addr_nx;
    logic [6:0]          cnt, cnt_nx, rem;
    logic [7:0]          par_acc, par_acc_nx, par_rx, par_rx_nx;
    logic                err_nx, busy_c, lfd_c, hdr_take, abort;
    logic [2:0]          we_c;
    logic [1:0]          hdr_addr;
    logic [5:0]          hdr_len;
    logic [2:0][TO_W-1:0] to_cnt;

    assign hdr_addr  = data_in[1:0];
    assign hdr_len   = data_in[7:2];
    assign data_out  = data_in;
    assign vld_out   = ~fifo_empty;
    assign write_enb = reset ? 3'b000 : we_c;
    assign lfd_state = ~reset & lfd_c;
    assign busy      = ~reset & busy_c;

    always_comb begin
        state_nx   = state;
        addr_nx    = addr_q;
        cnt_nx     = cnt;
        par_acc_nx = par_acc;
        par_rx_nx  = par_rx;
        err_nx     = err;
        busy_c     = 1'b0;
        lfd_c      = 1'b0;
        we_c       = 3'b000;
        hdr_take   = 1'b0;
        abort      = 1'b0;
        rem        = 7'd0;
        case (state)
            IDLE: begin
                if (pkt_valid) begin
                    if (hdr_addr == 2'd3) begin
                        cnt_nx   = {1'b0, hdr_len} + 7'd1;
                        state_nx = DROP;
                    end else if (fifo_empty[hdr_addr]) begin
                        hdr_take = 1'b1;
                    end else begin
                        busy_c   = 1'b1;
                        addr_nx  = hdr_addr;
                        state_nx = WAIT_EMPTY;
                    end
                end
            end
            WAIT_EMPTY: begin
                busy_c = ~fifo_empty[addr_q];
                if (pkt_valid && fifo_empty[addr_q]) hdr_take = 1'b1;
            end
            PAYLOAD: begin
                busy_c = fifo_full[addr_q];
                if (soft_reset[addr_q]) begin
                    abort = 1'b1;
                    rem   = cnt + 7'd1;
                end else if (pkt_valid && !busy_c) begin
                    we_c[addr_q] = 1'b1;
                    par_acc_nx   = par_acc ^ data_in;
                    cnt_nx       = cnt - 7'd1;
                    if (cnt == 7'd1) state_nx = PARITY;
                end
            end
            PARITY: begin
                busy_c = fifo_full[addr_q];
                if (soft_reset[addr_q]) begin
                    abort = 1'b1;
                    rem   = 7'd1;
                end else if (pkt_valid && !busy_c) begin
                    we_c[addr_q] = 1'b1;
                    par_rx_nx    = data_in;
                    state_nx     = CHECK;
                end
            end
            CHECK: begin
                busy_c   = 1'b1;
                err_nx   = (par_rx != par_acc);
                state_nx = IDLE;
            end
            DROP: begin
                if (pkt_valid) begin
                    cnt_nx = cnt - 7'd1;
                    if (cnt == 7'd1) state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase

        if (hdr_take) begin
            we_c[hdr_addr] = 1'b1;
            lfd_c          = 1'b1;
            addr_nx        = hdr_addr;
            cnt_nx         = {1'b0, hdr_len};
            par_acc_nx     = data_in;
            err_nx         = 1'b0;
            state_nx       = (hdr_len == 6'd0) ? PARITY : PAYLOAD;
        end

        // A flushed FIFO loses the packet; a byte taken in the abort cycle still counts as discarded.
        if (abort) begin
            if (pkt_valid && !busy_c) rem = rem - 7'd1;
            cnt_nx   = rem;
            state_nx = (rem == 7'd0) ? IDLE : DROP;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            addr_q  <= 2'd0;
            cnt     <= 7'd0;
            par_acc <= 8'd0;
            par_rx  <= 8'd0;
            err     <= 1'b0;
        end else begin
            state   <= state_nx;
            addr_q  <= addr_nx;
            cnt     <= cnt_nx;
            par_acc <= par_acc_nx;
            par_rx  <= par_rx_nx;
            err     <= err_nx;
        end
    end

    // Stall timer per port; firing also restarts the count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            to_cnt     <= '0;
            soft_reset <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                soft_reset[i] <= 1'b0;
                if (read_enb[i] || fifo_empty[i] || soft_reset[i]) begin
                    to_cnt[i] <= '0;
                end else if (to_cnt[i] == TO_W'(TIMEOUT - 1)) begin
                    to_cnt[i]     <= '0;
                    soft_reset[i] <= 1'b1;
                end else begin
                    to_cnt[i] <= to_cnt[i] + TO_W'(1);
                end
            end
        end
    end

`ifdef ROUTER_CTRL_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop_cnt <= 8'd0;
            perr_cnt <= 8'd0;
        end else begin
            if (state_nx == DROP && state != DROP && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
            if (state == CHECK && par_rx != par_acc && perr_cnt != 8'hFF)
                perr_cnt <= perr_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_router_pkt_ctrl.sv
// Scoreboard bench for router_pkt_ctrl: directed test-plan cases plus randomized packets.
module tb_router_pkt_ctrl;
    logic       clock = 1'b0;
    logic       reset;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic [2:0] fifo_full, fifo_empty, read_enb;
    logic [7:0] data_out;
    logic [2:0] write_enb, vld_out, soft_reset;
    logic       lfd_state, busy, err;
`ifdef ROUTER_CTRL_STATS_EN
    logic [7:0] drop_cnt, perr_cnt;
`endif

    router_pkt_ctrl #(.TIMEOUT(30), .TO_W(5)) dut (
        .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .read_enb(read_enb),
        .data_out(data_out), .write_enb(write_enb), .lfd_state(lfd_state),
        .busy(busy), .err(err), .vld_out(vld_out), .soft_reset(soft_reset)
`ifdef ROUTER_CTRL_STATS_EN
        , .drop_cnt(drop_cnt), .perr_cnt(perr_cnt)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [1:0] port;
        logic [7:0] b;
        logic       lfd;
    } wr_t;

    wr_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    bit  err_model = 1'b0;
    bit  rand_bp   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Hold the byte until the DUT takes it (pkt_valid & ~busy at a rising edge).
    task automatic send_byte(input logic [7:0] b, input bit gap);
        bit acc = 1'b0;
        if (gap && ($urandom % 3 == 0)) begin
            pkt_valid = 1'b0;
            repeat ($urandom_range(1, 3)) step();
        end
        data_in   = b;
        pkt_valid = 1'b1;
        for (int n = 0; n < 300 && !acc; n++) begin
            if (rand_bp) begin
                fifo_full  = ($urandom % 4 == 0) ? 3'($urandom) : 3'b000;
                fifo_empty = ($urandom % 3 == 0) ? 3'($urandom) : 3'b111;
            end
            @(negedge clock);
            acc = !busy;
            step();
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout byte=%0h never accepted within 300 cycles", b);
        end
    endtask

    task automatic send_packet(input logic [7:0] hdr, input logic [7:0] pl[$],
                               input logic [7:0] par, input bit gap);
        logic [1:0] a = hdr[1:0];
        logic [7:0] x = hdr;
        foreach (pl[i]) x ^= pl[i];
        if (a != 2'd3) begin
            exp_q.push_back('{port: a, b: hdr, lfd: 1'b1});
            foreach (pl[i]) exp_q.push_back('{port: a, b: pl[i], lfd: 1'b0});
            exp_q.push_back('{port: a, b: par, lfd: 1'b0});
        end
        send_byte(hdr, gap);
        if (a != 2'd3) chk("err_clear_on_hdr", 32'(err), 32'd0);
        foreach (pl[i]) send_byte(pl[i], gap);
        send_byte(par, gap);
        pkt_valid = 1'b0;
        if (a != 2'd3) begin
            err_model = (x != par);
            step();
            chk("err_after_check", 32'(err), 32'(err_model));
        end else begin
            chk("err_after_drop", 32'(err), 32'(err_model));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] pl[$];
        logic [7:0] par;
        int pulses, pos;

        // Monitor: every FIFO write must match the head of the scoreboard.
        fork
            forever begin : mon
                wr_t e;
                logic [2:0] oh;
                @(negedge clock);
                if (!reset) begin
                    if (write_enb != 3'b000) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_write write_enb=%b data=%0h", write_enb, data_out);
                        end else begin
                            e  = exp_q.pop_front();
                            oh = 3'b001 << e.port;
                            chk("wr_port", 32'(write_enb), 32'(oh));
                            chk("wr_data", 32'(data_out), 32'(e.b));
                            chk("wr_lfd", 32'(lfd_state), 32'(e.lfd));
                        end
                    end else if (lfd_state) begin
                        checks++;
                        failures++;
                        $display("FAIL lfd_without_write lfd_state=1 write_enb=000");
                    end
                end
            end
        join_none

        // Reset: outputs forced low even with a valid header presented.
        reset      = 1'b1;
        pkt_valid  = 1'b1;
        data_in    = 8'h11;
        fifo_full  = 3'b000;
        fifo_empty = 3'b010;
        read_enb   = 3'b111;
        repeat (3) step();
        @(negedge clock);
        chk("rst_write_enb", 32'(write_enb), 32'd0);
        chk("rst_lfd", 32'(lfd_state), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_soft_reset", 32'(soft_reset), 32'd0);
        chk("rst_vld_out", 32'(vld_out), 32'b101);
        step();
        pkt_valid  = 1'b0;
        fifo_empty = 3'b111;
        reset      = 1'b0;
        repeat (2) step();

        // Good packet, then bad parity, then invalid address, then good packet to port 0.
        pl.delete();
        pl.push_back(8'hA5); pl.push_back(8'h3C); pl.push_back(8'h0F); pl.push_back(8'hF0);
        send_packet(8'h11, pl, 8'h77, 1'b0);
        send_packet(8'h11, pl, 8'h00, 1'b0);
        chk("err_bad_parity", 32'(err), 32'd1);
        pl.delete();
        pl.push_back(8'h12); pl.push_back(8'h34);
        send_packet(8'h0B, pl, 8'h56, 1'b0);
        pl.delete();
        pl.push_back(8'hDE); pl.push_back(8'hAD); pl.push_back(8'hBE); pl.push_back(8'hEF);
        par = 8'h10 ^ 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF;
        send_packet(8'h10, pl, par, 1'b0);

        // Back-pressure: fifo_full[1] for three cycles while 8'h3C waits.
        exp_q.push_back('{port: 2'd1, b: 8'h11, lfd: 1'b1});
        exp_q.push_back('{port: 2'd1, b: 8'hA5, lfd: 1'b0});
        exp_q.push_back('{port: 2'd1, b: 8'h3C, lfd: 1'b0});
        exp_q.push_back('{port: 2'd1, b: 8'h0F, lfd: 1'b0});
        exp_q.push_back('{port: 2'd1, b: 8'hF0, lfd: 1'b0});
        exp_q.push_back('{port: 2'd1, b: 8'h77, lfd: 1'b0});
        send_byte(8'h11, 1'b0);
        send_byte(8'hA5, 1'b0);
        data_in   = 8'h3C;
        pkt_valid = 1'b1;
        fifo_full = 3'b010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("bp_busy", 32'(busy), 32'd1);
            chk("bp_no_write", 32'(write_enb), 32'd0);
            step();
        end
        fifo_full = 3'b000;
        @(negedge clock);
        chk("bp_release_busy", 32'(busy), 32'd0);
        step();
        send_byte(8'h0F, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h77, 1'b0);
        pkt_valid = 1'b0;
        err_model = 1'b0;
        step();
        chk("bp_err", 32'(err), 32'd0);

        // Header wait: port 2 not empty when header 8'h06 arrives.
        exp_q.push_back('{port: 2'd2, b: 8'h06, lfd: 1'b1});
        exp_q.push_back('{port: 2'd2, b: 8'h5A, lfd: 1'b0});
        exp_q.push_back('{port: 2'd2, b: 8'h5C, lfd: 1'b0});
        fifo_empty = 3'b011;
        data_in    = 8'h06;
        pkt_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("hw_busy", 32'(busy), 32'd1);
            chk("hw_no_write", 32'(write_enb), 32'd0);
            step();
        end
        fifo_empty = 3'b111;
        @(negedge clock);
        chk("hw_hdr_write", 32'(write_enb), 32'b100);
        chk("hw_hdr_lfd", 32'(lfd_state), 32'd1);
        step();
        send_byte(8'h5A, 1'b0);
        send_byte(8'h5C, 1'b0);
        pkt_valid = 1'b0;
        step();
        chk("hw_err", 32'(err), 32'd0);

        // Randomized packets with back-pressure, header waits and valid gaps.
        rand_bp = 1'b1;
        for (int p = 0; p < 60; p++) begin
            logic [1:0] a;
            logic [5:0] len;
            logic [7:0] h, x;
            a   = 2'($urandom % 4);
            len = 6'($urandom_range(0, 7));
            h   = {len, a};
            x   = h;
            pl.delete();
            for (int i = 0; i < int'(len); i++) begin
                pl.push_back(8'($urandom));
                x ^= pl[i];
            end
            par = ($urandom % 5 == 0) ? (x ^ (8'h01 << ($urandom % 8))) : x;
            send_packet(h, pl, par, 1'b1);
        end
        rand_bp    = 1'b0;
        fifo_full  = 3'b000;
        fifo_empty = 3'b111;
        repeat (3) step();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        // Timeout: port 0 stalled continuously.
        @(negedge clock);
        fifo_empty = 3'b110;
        read_enb   = 3'b110;
        pulses = 0;
        pos    = 0;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clock);
            if (soft_reset[0]) begin
                pulses++;
                if (pos == 0) pos = k;
            end
        end
        chk("to_pulses", 32'(pulses), 32'd1);
        chk("to_pulse_cycle", 32'(pos), 32'd30);
        chk("to_other_ports", 32'(soft_reset[2:1]), 32'd0);
        fifo_empty = 3'b111;
        read_enb   = 3'b111;
        repeat (3) @(negedge clock);

        // Timeout restarted by a read at cycle 20.
        fifo_empty = 3'b110;
        read_enb   = 3'b110;
        pulses = 0;
        pos    = 0;
        for (int k = 1; k <= 55; k++) begin
            @(negedge clock);
            if (soft_reset[0]) begin
                pulses++;
                if (pos == 0) pos = k;
            end
            if (k == 19) read_enb[0] = 1'b1;
            if (k == 20) read_enb[0] = 1'b0;
        end
        chk("to_read_pulses", 32'(pulses), 32'd1);
        chk("to_read_pulse_cycle", 32'(pos), 32'd50);
        fifo_empty = 3'b111;
        read_enb   = 3'b111;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/router_pkt_ctrl.md
Name: router_pkt_ctrl

Overview:
- Packet write controller for the router's three output FIFOs (router_fifo x3).
- Accepts the 1-byte-wide input packet stream and decodes the header address.
- Steers bytes into the selected FIFO with write_enb/lfd_state, applies back-pressure through busy, and checks packet parity.
- Per output port, issues a soft_reset to the FIFO when its reader stalls past a timeout.

Parameters:
- TIMEOUT, 30: cycles a non-empty FIFO may go unread before its soft_reset pulses.
- TO_W, 5: width of each timeout counter; must satisfy 2**TO_W > TIMEOUT.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pkt_valid  in  1  data_in holds a valid packet byte.
- data_in  in  8  packet byte. Header format: [7:2] payload length, [1:0] address.
- fifo_full  in  3  full flag from each FIFO.
- fifo_empty  in  3  empty flag from each FIFO.
- read_enb  in  3  read enable from each output-port reader.
- data_out  out  8  byte to FIFO data_in; combinational copy of data_in.
- write_enb  out  3  one-hot FIFO write enable; combinational.
- lfd_state  out  1  high with the header write only; combinational.
- busy  out  1  back-pressure to the source; combinational.
- err  out  1  parity error flag; registered.
- vld_out  out  3  equals ~fifo_empty.
- soft_reset  out  3  1-cycle flush pulse per FIFO; registered.

Behaviour:
- Reset:
  - state=IDLE, err=0, soft_reset=0, all counters 0.
  - write_enb, lfd_state and busy are forced to 0 while reset is high.
- Accept rule: a byte is accepted at a rising edge iff pkt_valid=1 and busy=0. An unaccepted byte must be held by the source.
- Timing: zero latency. write_enb[addr] is asserted in the same cycle as the accept, so the FIFO captures the byte at that same edge.
- busy by state:
  - IDLE: pkt_valid & addr!=3 & ~fifo_empty[addr].
  - WAIT_EMPTY: ~fifo_empty[addr_q].
  - PAYLOAD and PARITY: fifo_full[addr_q].
  - CHECK: 1.
  - DROP: 0.
- IDLE:
  - addr==3 and pkt_valid: consume the header with no write, load cnt=len+1, go to DROP.
  - Valid addr with the target FIFO empty: accept the header.
    - Assert write_enb[addr]=1 and lfd_state=1.
    - Latch addr_q and cnt=len; set par_acc=header; clear err.
    - Next state is PAYLOAD, or PARITY if len==0.
  - Valid addr with the target FIFO not empty: go to WAIT_EMPTY; the header is not consumed.
- WAIT_EMPTY: when fifo_empty[addr_q]=1, the header is accepted exactly as in IDLE.
- PAYLOAD: each accept writes the byte, does par_acc^=byte and cnt-=1. Accepting the byte with cnt==1 moves to PARITY.
- PARITY: the accept writes the byte, latches it into par_rx, and moves to CHECK.
- CHECK: one cycle; err <= (par_rx != par_acc); return to IDLE. err holds until the next valid header is accepted.
- DROP: each accepted byte decrements cnt with no write; return to IDLE when cnt hits 0.
- pkt_valid low mid-packet: stall in place, with no state or count change.
- Timeout, per port i:
  - to_cnt[i] increments while vld_out[i] & ~read_enb[i].
  - It clears on read_enb[i], on fifo_empty[i], or when soft_reset[i] fires.
  - When to_cnt[i] reaches TIMEOUT-1, soft_reset[i] is set to 1 for the next single cycle.
- soft_reset[addr_q] in PAYLOAD/PARITY: go to DROP with cnt = remaining bytes including parity. The rest of the packet is discarded and err is unchanged.
- fifo_full rising mid-packet: busy goes high in the same cycle and no byte is lost.

Optional Feature:
- Macro ROUTER_CTRL_STATS_EN.
- Defined: adds outputs drop_cnt[7:0] and perr_cnt[7:0], both registered and saturating at 255, cleared by reset.
  - drop_cnt increments on entry to DROP.
  - perr_cnt increments when CHECK detects a mismatch.
- Undefined: these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Good packet:
  - Stimulus: header 8'h11, payload 8'hA5 8'h3C 8'h0F 8'hF0, parity = XOR of all five bytes.
  - Response: six writes on write_enb=3'b010; lfd_state high only with the header; err=0; state returns to IDLE.
- Bad parity:
  - Stimulus: same packet with parity byte 8'h00.
  - Response: err=1 one cycle after the parity accept; err clears on the next valid header.
- Invalid address:
  - Stimulus: header 8'h0B (len 2, addr 3) followed by 3 bytes, then a good packet to addr 0.
  - Response: no write_enb during the first packet; all 6 bytes of the second packet written to FIFO0.
- Back-pressure:
  - Stimulus: fifo_full[1]=1 for 3 cycles mid-payload.
  - Response: busy=1 for exactly those 3 cycles, write_enb=0, no payload byte skipped or duplicated.
- Header wait:
  - Stimulus: fifo_empty[2]=0 when header 8'h06 arrives.
  - Response: busy=1 and state WAIT_EMPTY; header written the cycle fifo_empty[2] rises.
- Timeout:
  - Stimulus: fifo_empty[0]=0 and read_enb[0]=0 for 30 cycles.
  - Response: exactly one 1-cycle soft_reset[0] pulse. With a read_enb[0] pulse at cycle 20, no pulse occurs before cycle 50.
